lcd_bus_reader: RTL and testbench

//  Read-cycle engine for the HD44780-style 8-bit LCD bus (lcd_en/lcd_rs/lcd_rw/data).

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_phase_timer.sv | 26 ++
 rtl/lcd_bus_reader.sv | 199 +++++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus read engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_EN_LO = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned LCD_BF_BIT = 7;
  localparam int unsigned LCD_AC_MSB = 6;

  localparam logic RS_STATUS = 1'b0;
  localparam logic RS_DATA   = 1'b1;

  localparam int unsigned T_AS_DEF     = 3;
  localparam int unsigned T_EN_HI_DEF  = 25;
  localparam int unsigned T_EN_LO_DEF  = 25;
  localparam int unsigned POLL_MAX_DEF = 1000;
  localparam int unsigned POLL_W       = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; o_zero_c flags the last cycle of the current phase.
module lcd_phase_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-cycle engine for an HD44780-style 8-bit LCD bus: status/data reads with
// optional busy-flag polling and timeout.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS_CYC    = T_AS_DEF,
  parameter int unsigned T_EN_HI_CYC = T_EN_HI_DEF,
  parameter int unsigned T_EN_LO_CYC = T_EN_LO_DEF,
  parameter int unsigned POLL_MAX    = POLL_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rs,
  input  logic        req_poll,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_busy,
  output logic [6:0]  rsp_addr,
  output logic        rsp_timeout,
  output logic [15:0] rsp_polls,
  output logic        bus_busy,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  input  logic [7:0]  lcd_data_i
);

  localparam int unsigned PH_W = $clog2(max3(T_AS_CYC, T_EN_HI_CYC, T_EN_LO_CYC) + 1);
  localparam logic [PH_W-1:0] LD_AS = PH_W'(T_AS_CYC - 1);
  localparam logic [PH_W-1:0] LD_HI = PH_W'(T_EN_HI_CYC - 1);
  localparam logic [PH_W-1:0] LD_LO = PH_W'(T_EN_LO_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(POLL_MAX);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_ld;
  logic [PH_W-1:0]   w_ld_val;
  logic              w_zero;
  logic              w_accept;
  logic              w_reloop;
  logic              w_sample_en;
  logic              w_rs_nxt;
  logic              w_owns_nxt;

  logic              r_rs;
  logic              r_poll;
  logic [7:0]        r_sample;
  logic [POLL_W-1:0] r_polls;

  logic              r_req_ready;
  logic              r_bus_busy;
  logic              r_lcd_en;
  logic              r_lcd_rs;
  logic              r_lcd_rw;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp_data;
  logic              r_rsp_busy;
  logic [6:0]        r_rsp_addr;
  logic              r_rsp_timeout;
  logic [15:0]       r_rsp_polls;

  lcd_phase_timer #(.W(PH_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .o_zero_c   (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and phase-timer load control.
  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_val    = '0;
    w_accept    = 1'b0;
    w_reloop    = 1'b0;
    w_sample_en = 1'b0;
    w_rs_nxt    = r_rs;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_rs_nxt    = req_rs;
          w_state_nxt = ST_SETUP;
          w_ld        = 1'b1;
          w_ld_val    = LD_AS;
        end
      end
      ST_SETUP: begin
        if (w_zero) begin
          w_state_nxt = ST_EN_HI;
          w_ld        = 1'b1;
          w_ld_val    = LD_HI;
        end
      end
      ST_EN_HI: begin
        if (w_zero) begin
          w_sample_en = 1'b1;
          w_state_nxt = ST_EN_LO;
          w_ld        = 1'b1;
          w_ld_val    = LD_LO;
        end
      end
      ST_EN_LO: begin
        if (w_zero) begin
          if (r_poll && r_sample[LCD_BF_BIT] && (r_polls < POLL_LIMIT)) begin
            w_reloop    = 1'b1;
            w_state_nxt = ST_SETUP;
            w_ld        = 1'b1;
            w_ld_val    = LD_AS;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_owns_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_EN_HI) ||
                      (w_state_nxt == ST_EN_LO);

  // Request latch, bus sample and poll counter (saturating).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs     <= RS_STATUS;
      r_poll   <= 1'b0;
      r_sample <= '0;
      r_polls  <= '0;
    end else begin
      r_rs <= w_rs_nxt;
      if (w_accept) begin
        r_poll  <= req_poll && (req_rs == RS_STATUS);
        r_polls <= POLL_W'(1);
      end else if (w_reloop && (r_polls != '1)) begin
        r_polls <= r_polls + POLL_W'(1);
      end
      if (w_sample_en) r_sample <= lcd_data_i;
    end
  end

  // Bus strobes follow the next state so they are glitch-free register outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= 1'b1;
      r_bus_busy  <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_rw    <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_bus_busy  <= (w_state_nxt != ST_IDLE);
      r_lcd_en    <= (w_state_nxt == ST_EN_HI);
      r_lcd_rw    <= w_owns_nxt;
      r_lcd_rs    <= w_owns_nxt ? w_rs_nxt : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_busy    <= 1'b0;
      r_rsp_addr    <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_polls   <= '0;
    end else begin
      r_rsp_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_rsp_data    <= r_sample;
        r_rsp_busy    <= (r_rs == RS_STATUS) && r_sample[LCD_BF_BIT];
        r_rsp_addr    <= (r_rs == RS_STATUS) ? r_sample[LCD_AC_MSB:0] : 7'd0;
        r_rsp_timeout <= r_poll && r_sample[LCD_BF_BIT];
        r_rsp_polls   <= r_polls;
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign bus_busy    = r_bus_busy;
  assign lcd_en      = r_lcd_en;
  assign lcd_rs      = r_lcd_rs;
  assign lcd_rw      = r_lcd_rw;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_busy    = r_rsp_busy;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_polls   = r_rsp_polls;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: vector table, reset abort and bus protocol watch.
module tb_lcd_bus_reader;

  localparam int unsigned TAS  = 3;
  localparam int unsigned THI  = 25;
  localparam int unsigned TLO  = 25;
  localparam int unsigned PMAX = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rs;
  logic        req_poll;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_busy;
  logic [6:0]  rsp_addr;
  logic        rsp_timeout;
  logic [15:0] rsp_polls;
  logic        bus_busy;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data_i = 8'h00;

  lcd_bus_reader #(
    .T_AS_CYC(TAS), .T_EN_HI_CYC(THI), .T_EN_LO_CYC(TLO), .POLL_MAX(PMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_poll(req_poll),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_busy(rsp_busy), .rsp_addr(rsp_addr),
    .rsp_timeout(rsp_timeout), .rsp_polls(rsp_polls), .bus_busy(bus_busy),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data_i(lcd_data_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LCD model: the first bf_n reads of a request return bf_byte, later reads fin.
  int         rd_idx = 0;
  int         rd_base = 0;
  int         cur_bf = 0;
  logic [7:0] cur_bfbyte = 8'h00;
  logic [7:0] cur_fin = 8'h00;

  always @(posedge lcd_en) begin
    lcd_data_i <= ((rd_idx - rd_base) < cur_bf) ? cur_bfbyte : cur_fin;
    rd_idx     <= rd_idx + 1;
  end

  // Bus protocol watch: EN width, RS/RW stable while EN high, setup before EN rise.
  int   hi_cnt = 0;
  int   setup_cnt = 0;
  int   proto_viol = 0;
  int   pulses_ok = 0;
  logic p_en = 1'b0;
  logic p_rs = 1'b0;
  logic p_rw = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hi_cnt    = 0;
      setup_cnt = 0;
    end else begin
      if (lcd_en && p_en && (lcd_rs !== p_rs || lcd_rw !== p_rw)) begin
        proto_viol++;
        $display("protocol: RS/RW moved while EN high at t=%0t", $time);
      end
      if (lcd_en && !p_en && (setup_cnt < int'(TAS) || !lcd_rw)) begin
        proto_viol++;
        $display("protocol: setup %0d cycles before EN rise at t=%0t", setup_cnt, $time);
      end
      if (!lcd_en && p_en) begin
        if (hi_cnt != int'(THI)) begin
          proto_viol++;
          $display("protocol: EN high %0d cycles at t=%0t", hi_cnt, $time);
        end else begin
          pulses_ok++;
        end
      end
      hi_cnt = lcd_en ? hi_cnt + 1 : 0;
      if (!lcd_en && lcd_rw) setup_cnt = (lcd_rs === p_rs && p_rw) ? setup_cnt + 1 : 1;
      else                   setup_cnt = 0;
    end
    p_en = lcd_en;
    p_rs = lcd_rs;
    p_rw = lcd_rw;
  end

  typedef struct {
    logic       rs;
    logic       poll;
    int         bf_n;
    logic [7:0] bf_byte;
    logic [7:0] fin;
    logic [7:0] e_data;
    logic       e_busy;
    logic [6:0] e_addr;
    logic       e_to;
    int         e_polls;
    int         e_lat;
    logic       hold;
  } vec_t;

  vec_t vt[7];
  int   tot_pulses = 0;

  task automatic run_vec(input vec_t v, input string tag);
    int  cyc;
    bit  got;
    @(negedge clk);
    chk({tag, ".ready_before"}, 32'(req_ready), 32'd1);
    rd_base    = rd_idx;
    cur_bf     = v.bf_n;
    cur_bfbyte = v.bf_byte;
    cur_fin    = v.fin;
    req_rs     = v.rs;
    req_poll   = v.poll;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!v.hold) req_valid = 1'b0;
    chk({tag, ".busy_after_accept"}, {30'd0, bus_busy, req_ready}, 32'd2);
    cyc = 0;
    got = 1'b0;
    while (cyc < 2000 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rsp_valid) got = 1'b1;
    end
    req_valid = 1'b0;
    chk({tag, ".latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(v.e_lat));
    chk({tag, ".data"}, 32'(rsp_data), 32'(v.e_data));
    chk({tag, ".busy"}, 32'(rsp_busy), 32'(v.e_busy));
    chk({tag, ".addr"}, 32'(rsp_addr), 32'(v.e_addr));
    chk({tag, ".timeout"}, 32'(rsp_timeout), 32'(v.e_to));
    chk({tag, ".polls"}, 32'(rsp_polls), 32'(v.e_polls));
    chk({tag, ".en_pulses"}, 32'(rd_idx - rd_base), 32'(v.e_polls));
    chk({tag, ".idle_at_rsp"}, {30'd0, bus_busy, req_ready}, 32'd1);
    tot_pulses += v.e_polls;
    @(posedge clk);
    #1;
    chk({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_hold"}, 32'(rsp_data), 32'(v.e_data));
  endtask

  initial begin
    int  w;
    bit  saw;
    //          rs    poll  bf_n bf_byte fin    data   busy  addr   to    polls lat  hold
    vt[0] = '{1'b0, 1'b0, 0,  8'h00, 8'h25, 8'h25, 1'b0, 7'h25, 1'b0, 1, 54,  1'b0};
    vt[1] = '{1'b1, 1'b1, 0,  8'h00, 8'hC1, 8'hC1, 1'b0, 7'h00, 1'b0, 1, 54,  1'b0};
    vt[2] = '{1'b0, 1'b1, 3,  8'h8A, 8'h0A, 8'h0A, 1'b0, 7'h0A, 1'b0, 4, 213, 1'b0};
    vt[3] = '{1'b0, 1'b1, 99, 8'hB3, 8'h00, 8'hB3, 1'b1, 7'h33, 1'b1, 5, 266, 1'b0};
    vt[4] = '{1'b0, 1'b0, 0,  8'h00, 8'h9F, 8'h9F, 1'b1, 7'h1F, 1'b0, 1, 54,  1'b0};
    vt[5] = '{1'b1, 1'b0, 0,  8'h00, 8'h5A, 8'h5A, 1'b0, 7'h00, 1'b0, 1, 54,  1'b1};
    vt[6] = '{1'b0, 1'b1, 1,  8'hC4, 8'h44, 8'h44, 1'b0, 7'h44, 1'b0, 2, 107, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_poll  = 1'b0;
    #1;
    chk("reset.lcd", {29'd0, lcd_en, lcd_rs, lcd_rw}, 32'd0);
    chk("reset.rsp", {15'd0, rsp_valid, rsp_data, rsp_busy, rsp_addr}, 32'd0);
    chk("reset.rsp_polls_to", {15'd0, rsp_timeout, rsp_polls}, 32'd0);
    chk("reset.ready_busy", {30'd0, req_ready, bus_busy}, 32'd2);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset while EN is high aborts the read with no response.
    @(negedge clk);
    rd_base = rd_idx;
    cur_bf  = 0;
    cur_fin = 8'h25;
    req_rs = 1'b0; req_poll = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    while (!lcd_en && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("abort.en_seen", 32'(lcd_en), 32'd1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.en_low", {29'd0, lcd_en, lcd_rs, lcd_rw}, 32'd0);
    chk("abort.idle", {29'd0, rsp_valid, req_ready, bus_busy}, 32'd2);
    chk("abort.cleared", {8'd0, rsp_data, rsp_polls}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (rsp_valid || lcd_en) saw = 1'b1;
    end
    chk("abort.no_activity", 32'(saw), 32'd0);

    run_vec(vt[0], "after_abort");

    chk("protocol.violations", 32'(proto_viol), 32'd0);
    chk("protocol.clean_pulses", 32'(pulses_ok), 32'(tot_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
